draw_port_arbiter: RTL and testbench

- Shares the single VGA adapter write port (x, y, colour, plot) among up to NREQ drawing requesters, e.g. brick populate/remove, paddle erase/draw, ball erase/draw.
- Each requester asks for one solid rectangle. The block grants requesters round-robin and rasterises the granted rectangle one pixel per clock. It then pulses a per-requester done, which replaces the per-object "drawing_x" busy flags the main control FSM waits on.

---
 rtl/draw_port_arbiter.sv | 154 +++++++++++++++
 tb/tb_draw_port_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/draw_port_arbiter.sv
// Round-robin owner of the VGA write port: rasterises one requester's solid rectangle per grant, one pixel per clock.
// Latency: first pixel one cycle after acceptance, done w*h cycles later; other requests wait in IDLE until the port frees.
module draw_port_arbiter #(
  parameter int NREQ = 4,
  parameter int XW   = 8,
  parameter int YW   = 7,
  parameter int CW   = 3,
  parameter int XMAX = 160,
  parameter int YMAX = 120
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [NREQ-1:0]    i_req,
  input  logic [NREQ*XW-1:0] i_rect_x,
  input  logic [NREQ*YW-1:0] i_rect_y,
  input  logic [NREQ*XW-1:0] i_rect_w,
  input  logic [NREQ*YW-1:0] i_rect_h,
  input  logic [NREQ*CW-1:0] i_rect_col,
  output logic [NREQ-1:0]    o_grant,
  output logic [NREQ-1:0]    o_done,
  output logic               o_busy,
  output logic [XW-1:0]      o_vga_x,
  output logic [YW-1:0]      o_vga_y,
  output logic [CW-1:0]      o_vga_colour,
  output logic               o_vga_plot
);

  localparam int PW = $clog2(NREQ);

  typedef enum logic [1:0] {S_IDLE, S_DRAW, S_DONE} state_t;

  state_t          r_state;
  logic [NREQ-1:0] r_grant;
  logic [NREQ-1:0] r_done;
  logic [PW-1:0]   r_rr_ptr;
  logic [XW-1:0]   r_bx, r_bw, r_cx;
  logic [YW-1:0]   r_by, r_bh, r_cy;
  logic [CW-1:0]   r_col;

  logic            w_found;
  logic [PW-1:0]   w_win;
  logic [PW-1:0]   w_idx;
  logic [PW:0]     w_sum;
  logic [PW-1:0]   w_next_rr;
  logic [NREQ-1:0] w_win_oh;
  logic [XW-1:0]   w_sel_x, w_sel_w;
  logic [YW-1:0]   w_sel_y, w_sel_h;
  logic [CW-1:0]   w_sel_col;
  logic [XW:0]     w_sum_x;
  logic [YW:0]     w_sum_y;

  // First asserted request at or after the round-robin pointer, wrapping modulo NREQ.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    w_sum   = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_sum = {1'b0, r_rr_ptr} + (PW+1)'(k);
      if (w_sum >= (PW+1)'(NREQ)) begin
        w_sum = w_sum - (PW+1)'(NREQ);
      end
      w_idx = w_sum[PW-1:0];
      if (!w_found && i_req[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  assign w_next_rr = (w_win == PW'(NREQ-1)) ? '0 : w_win + PW'(1);
  assign w_win_oh  = {{(NREQ-1){1'b0}}, 1'b1} << w_win;
  assign w_sel_x   = i_rect_x[w_win*XW +: XW];
  assign w_sel_y   = i_rect_y[w_win*YW +: YW];
  assign w_sel_w   = i_rect_w[w_win*XW +: XW];
  assign w_sel_h   = i_rect_h[w_win*YW +: YW];
  assign w_sel_col = i_rect_col[w_win*CW +: CW];

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state  <= S_IDLE;
      r_grant  <= '0;
      r_done   <= '0;
      r_rr_ptr <= '0;
      r_bx     <= '0;
      r_by     <= '0;
      r_bw     <= '0;
      r_bh     <= '0;
      r_col    <= '0;
      r_cx     <= '0;
      r_cy     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= '0;
          if (w_found) begin
            r_grant  <= w_win_oh;
            r_rr_ptr <= w_next_rr;
            r_bx     <= w_sel_x;
            r_by     <= w_sel_y;
            r_bw     <= w_sel_w;
            r_bh     <= w_sel_h;
            r_col    <= w_sel_col;
            r_cx     <= '0;
            r_cy     <= '0;
            // Empty rectangles skip DRAW entirely.
            if (w_sel_w != '0 && w_sel_h != '0) begin
              r_state <= S_DRAW;
            end else begin
              r_state <= S_DONE;
              r_done  <= w_win_oh;
            end
          end
        end
        S_DRAW: begin
          if (r_cx == r_bw - XW'(1)) begin
            r_cx <= '0;
            if (r_cy == r_bh - YW'(1)) begin
              r_state <= S_DONE;
              r_done  <= r_grant;
            end else begin
              r_cy <= r_cy + YW'(1);
            end
          end else begin
            r_cx <= r_cx + XW'(1);
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_grant <= '0;
          r_done  <= '0;
        end
        default: begin
          r_state <= S_IDLE;
          r_grant <= '0;
          r_done  <= '0;
        end
      endcase
    end
  end

  // One extra bit so a sum that overflows the coordinate width clips instead of wrapping.
  assign w_sum_x = {1'b0, r_bx} + {1'b0, r_cx};
  assign w_sum_y = {1'b0, r_by} + {1'b0, r_cy};

  assign o_grant      = r_grant;
  assign o_done       = r_done;
  assign o_busy       = (r_state != S_IDLE);
  assign o_vga_x      = w_sum_x[XW-1:0];
  assign o_vga_y      = w_sum_y[YW-1:0];
  assign o_vga_colour = r_col;
  assign o_vga_plot   = (r_state == S_DRAW) && (w_sum_x < (XW+1)'(XMAX)) && (w_sum_y < (YW+1)'(YMAX));

endmodule

// File: tb/tb_draw_port_arbiter.sv
// Randomised and directed stimulus for draw_port_arbiter, checked cycle by cycle against a transaction-level pixel model.
module tb_draw_port_arbiter;

  localparam int NREQ = 4;
  localparam int XW   = 8;
  localparam int YW   = 7;
  localparam int CW   = 3;
  localparam int XMAX = 160;
  localparam int YMAX = 120;

  logic               clk;
  logic               rst;
  logic [NREQ-1:0]    req;
  logic [NREQ*XW-1:0] rect_x, rect_w;
  logic [NREQ*YW-1:0] rect_y, rect_h;
  logic [NREQ*CW-1:0] rect_col;
  logic [NREQ-1:0]    grant, done;
  logic               busy, vga_plot;
  logic [XW-1:0]      vga_x;
  logic [YW-1:0]      vga_y;
  logic [CW-1:0]      vga_colour;

  logic [XW-1:0] rx[NREQ];
  logic [XW-1:0] rw[NREQ];
  logic [YW-1:0] ry[NREQ];
  logic [YW-1:0] rh[NREQ];
  logic [CW-1:0] rc[NREQ];

  always_comb begin
    rect_x = '0; rect_y = '0; rect_w = '0; rect_h = '0; rect_col = '0;
    for (int i = 0; i < NREQ; i++) begin
      rect_x[i*XW +: XW]   = rx[i];
      rect_y[i*YW +: YW]   = ry[i];
      rect_w[i*XW +: XW]   = rw[i];
      rect_h[i*YW +: YW]   = rh[i];
      rect_col[i*CW +: CW] = rc[i];
    end
  end

  draw_port_arbiter #(
    .NREQ(NREQ), .XW(XW), .YW(YW), .CW(CW), .XMAX(XMAX), .YMAX(YMAX)
  ) dut (
    .i_clk(clk), .i_reset(rst), .i_req(req),
    .i_rect_x(rect_x), .i_rect_y(rect_y), .i_rect_w(rect_w), .i_rect_h(rect_h), .i_rect_col(rect_col),
    .o_grant(grant), .o_done(done), .o_busy(busy),
    .o_vga_x(vga_x), .o_vga_y(vga_y), .o_vga_colour(vga_colour), .o_vga_plot(vga_plot)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs for one clock cycle.
  typedef struct {
    logic [NREQ-1:0] grant;
    logic [NREQ-1:0] done;
    bit              busy;
    bit              draw;
    bit              plot;
    int              x;
    int              y;
    int              col;
    bit              zero;
  } exp_t;

  exp_t cur;
  exp_t exp_q[$];
  int   rr;
  int   n_vec;
  int   n_bad;
  logic [NREQ-1:0] hold;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, want, $time);
    end
  endtask

  function automatic exp_t idle_entry();
    exp_t e;
    e = '{grant: '0, done: '0, busy: 1'b0, draw: 1'b0, plot: 1'b0, x: 0, y: 0, col: 0, zero: 1'b0};
    return e;
  endfunction

  // Arbitrate and expand the winning rectangle into its list of per-cycle expectations.
  task automatic start_rect();
    int win;
    int bx, by, bw, bh, col;
    exp_t e;
    win = -1;
    for (int k = 0; k < NREQ; k++) begin
      int j;
      j = (rr + k) % NREQ;
      if (win < 0 && req[j]) win = j;
    end
    rr  = (win + 1) % NREQ;
    bx  = int'(rx[win]); by = int'(ry[win]);
    bw  = int'(rw[win]); bh = int'(rh[win]);
    col = int'(rc[win]);
    for (int yy = 0; yy < bh; yy++) begin
      for (int xx = 0; xx < bw; xx++) begin
        e = idle_entry();
        e.grant = NREQ'(1) << win;
        e.busy  = 1'b1;
        e.draw  = 1'b1;
        e.x     = bx + xx;
        e.y     = by + yy;
        e.col   = col;
        e.plot  = (e.x < XMAX) && (e.y < YMAX);
        exp_q.push_back(e);
      end
    end
    e = idle_entry();
    e.grant = NREQ'(1) << win;
    e.done  = NREQ'(1) << win;
    e.busy  = 1'b1;
    exp_q.push_back(e);
  endtask

  task automatic model_edge();
    if (rst) begin
      exp_q.delete();
      rr       = 0;
      cur      = idle_entry();
      cur.zero = 1'b1;
    end else if (cur.busy) begin
      if (exp_q.size() > 0) cur = exp_q.pop_front();
      else cur = idle_entry();
    end else if (req != '0) begin
      start_rect();
      cur = exp_q.pop_front();
    end else begin
      cur = idle_entry();
    end
  endtask

  task automatic compare();
    check_eq("grant", 32'(grant), 32'(cur.grant));
    check_eq("done", 32'(done), 32'(cur.done));
    check_eq("busy", 32'(busy), 32'(cur.busy));
    check_eq("vga_plot", 32'(vga_plot), 32'(cur.plot));
    if (cur.draw) begin
      check_eq("vga_x", 32'(vga_x), 32'(cur.x % 256));
      check_eq("vga_y", 32'(vga_y), 32'(cur.y % 128));
      check_eq("vga_colour", 32'(vga_colour), 32'(cur.col));
    end
    if (cur.zero) begin
      check_eq("rst_vga_x", 32'(vga_x), 32'd0);
      check_eq("rst_vga_y", 32'(vga_y), 32'd0);
      check_eq("rst_vga_colour", 32'(vga_colour), 32'd0);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare();
  endtask

  task automatic auto_drop();
    for (int i = 0; i < NREQ; i++) begin
      if (cur.done[i] && !hold[i]) req[i] = 1'b0;
    end
  endtask

  task automatic set_rect(input int i, input int x, input int y, input int w, input int h, input int c);
    rx[i] = XW'(x); ry[i] = YW'(y); rw[i] = XW'(w); rh[i] = YW'(h); rc[i] = CW'(c);
  endtask

  task automatic rand_rect(input int i);
    int x, y;
    x = ($urandom_range(0, 3) == 0) ? int'($urandom_range(150, 255)) : int'($urandom_range(0, 159));
    y = ($urandom_range(0, 3) == 0) ? int'($urandom_range(110, 127)) : int'($urandom_range(0, 119));
    set_rect(i, x, y, int'($urandom_range(0, 6)), int'($urandom_range(0, 4)), int'($urandom_range(0, 7)));
  endtask

  task automatic run_until_idle(input int max);
    int n;
    for (n = 0; n < max; n++) begin
      step();
      auto_drop();
      if (!cur.busy && req == '0) break;
    end
    if (n >= max) check_eq("idle_timeout", 32'(n), 32'd0);
    step();
  endtask

  initial begin
    n_vec = 0; n_bad = 0; rr = 0; hold = '0;
    cur = idle_entry();
    rst = 1'b1; req = '0;
    for (int i = 0; i < NREQ; i++) set_rect(i, 0, 0, 0, 0, 0);
    step(); step();
    rst = 1'b0;
    step();

    // Single 4x2 rectangle, row-major raster.
    set_rect(0, 10, 20, 4, 2, 5);
    req = 4'b0001;
    run_until_idle(50);

    // Two requesters held continuously alternate.
    set_rect(0, 1, 1, 1, 1, 2);
    set_rect(2, 3, 3, 1, 1, 6);
    hold = 4'b0101; req = 4'b0101;
    repeat (12) begin step(); auto_drop(); end
    hold = '0;
    run_until_idle(50);

    // Zero-width rectangle goes straight to done.
    set_rect(2, 30, 30, 0, 5, 3);
    req = 4'b0100;
    run_until_idle(20);

    // Rectangle straddling the bottom-right corner is clipped.
    set_rect(1, 158, 119, 4, 2, 6);
    req = 4'b0010;
    run_until_idle(30);

    // Reset in the third DRAW cycle abandons the rectangle and the pointer.
    set_rect(2, 0, 0, 1, 1, 1);
    req = 4'b0100;
    run_until_idle(20);
    set_rect(0, 40, 50, 4, 4, 2);
    set_rect(1, 5, 5, 2, 2, 4);
    req = 4'b0011;
    step(); step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    run_until_idle(100);

    // All four requesting from reset; rect_x scrambled while drawing.
    rst = 1'b1; step(); rst = 1'b0;
    for (int i = 0; i < NREQ; i++) set_rect(i, 20 * i, 10 * i, 2, 2, i + 1);
    hold = 4'b0001; req = 4'b1111;
    repeat (25) begin
      step(); auto_drop();
      for (int i = 0; i < NREQ; i++) if (cur.grant[i]) rx[i] = XW'($urandom);
    end
    hold = '0;
    run_until_idle(200);

    // Randomised traffic with occasional resets.
    for (int n = 0; n < 3000; n++) begin
      step();
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 399) == 0) rst = 1'b1;
      for (int i = 0; i < NREQ; i++) begin
        if (cur.done[i]) begin
          req[i] = ($urandom_range(0, 2) == 0);
          if (req[i]) rand_rect(i);
        end else if (!req[i]) begin
          if ($urandom_range(0, 7) == 0) begin
            rand_rect(i);
            req[i] = 1'b1;
          end
        end else if (!cur.grant[i] && $urandom_range(0, 63) == 0) begin
          req[i] = 1'b0;
        end
      end
      if ($urandom_range(0, 3) == 0) rand_rect(int'($urandom_range(0, NREQ-1)));
    end
    rst = 1'b0;
    hold = '0;
    run_until_idle(500);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
